// File: rtl/pingpong_particle_buffer.sv
// Two-bank particle state store: the updater fills the back bank while readers see the front bank.
// The banks trade roles in one cycle once every live particle has been written this frame.
module pingpong_particle_buffer #(
  parameter int DIMS          = 2,
  parameter int MAX_PARTICLES = 128,
  parameter int ADDR_WIDTH    = 16,
  parameter int RD_LATENCY    = 2,
  localparam int W            = 16 * DIMS * 2,
  localparam int IDX_W        = (MAX_PARTICLES > 1) ? $clog2(MAX_PARTICLES) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in_n,
  input  logic [15:0]           particle_count,
  input  logic                  restart,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [W-1:0]          init_data,
  input  logic                  init_done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [W-1:0]          rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [W-1:0]          wr_data,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_sel,
  output logic [ADDR_WIDTH-1:0] write_count,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_PEND} state_t;

  state_t                  state_q, state_d;
  logic                    front_sel_q, front_sel_d;
  logic [ADDR_WIDTH-1:0]   write_count_q, write_count_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic [MAX_PARTICLES-1:0] bitmap_q, bitmap_d;
  logic                    err_q, err_d;
  logic                    swap_done_q, swap_done_d;
  logic                    rd_v1_q, rd_v1_d;
  logic                    rd_sel1_q, rd_sel1_d;

  logic                    run_like, wr_in_range, wr_dup, wr_mem_en, wr_accept;
  logic                    init_mem_en, swap_fire, err_set;
  logic [ADDR_WIDTH-1:0]   wc_inc;
  logic [IDX_W-1:0]        wr_idx, rd_idx, mem_wr_idx;
  logic [W-1:0]            mem_wr_data;
  logic [W-1:0]            rd_word1;

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT:        if (init_done) state_d = S_RUN;
        S_RUN, S_PEND: begin
          if (swap_fire)     state_d = S_RUN;
          else if (swap_req) state_d = S_PEND;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != S_RUN);
    run_like    = (state_q == S_RUN) || (state_q == S_PEND);
    wr_in_range = (wr_addr < count_q);
    wr_dup      = bitmap_q[wr_idx];
    wr_mem_en   = !restart && run_like && wr_en && wr_in_range;
    wr_accept   = wr_mem_en && !wr_dup;
    init_mem_en = !restart && (state_q == S_INIT) && init_we;
    wc_inc      = write_count_q + ADDR_WIDTH'(wr_accept);
    // Completion includes the write accepted on this very edge.
    swap_fire   = !restart && run_like && (swap_req || (state_q == S_PEND)) && (wc_inc == count_q);
    err_set     = (rd_en && (rd_addr >= count_q))
                || (wr_en && (!run_like || !wr_in_range || wr_dup))
                || (init_we && ((state_q != S_INIT) || (init_addr >= count_q)))
                || (swap_req && !run_like);
    mem_wr_idx  = init_mem_en ? init_addr[IDX_W-1:0] : wr_idx;
    mem_wr_data = init_mem_en ? init_data : wr_data;

    front_sel_d   = front_sel_q;
    write_count_d = write_count_q;
    count_d       = count_q;
    bitmap_d      = bitmap_q;
    err_d         = err_q;
    swap_done_d   = swap_fire;
    rd_v1_d       = rd_en;
    rd_sel1_d     = rd_en ? front_sel_q : rd_sel1_q;

    if (restart) begin
      bitmap_d      = '0;
      write_count_d = '0;
      err_d         = 1'b0;
      count_d       = ADDR_WIDTH'(particle_count);
    end else begin
      err_d = err_q | err_set;
      if (wr_accept) begin
        bitmap_d[wr_idx] = 1'b1;
        write_count_d    = wc_inc;
      end
      if (swap_fire) begin
        bitmap_d      = '0;
        write_count_d = '0;
        count_d       = ADDR_WIDTH'(particle_count);
        front_sel_d   = ~front_sel_q;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      front_sel_q   <= 1'b0;
      write_count_q <= '0;
      count_q       <= '0;
      bitmap_q      <= '0;
      err_q         <= 1'b0;
      swap_done_q   <= 1'b0;
      rd_v1_q       <= 1'b0;
      rd_sel1_q     <= 1'b0;
    end else begin
      front_sel_q   <= front_sel_d;
      write_count_q <= write_count_d;
      count_q       <= count_d;
      bitmap_q      <= bitmap_d;
      err_q         <= err_d;
      swap_done_q   <= swap_done_d;
      rd_v1_q       <= rd_v1_d;
      rd_sel1_q     <= rd_sel1_d;
    end
  end

  // Bank gi is written by the updater only while it is the back bank; init writes both.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [W-1:0] mem [MAX_PARTICLES];
    logic [W-1:0] rd_raw_q;
    logic         we;
    assign we = init_mem_en || (wr_mem_en && (front_sel_q == ((gi == 0) ? 1'b1 : 1'b0)));
    always_ff @(posedge clk_in) begin
      if (we)    mem[mem_wr_idx] <= mem_wr_data;
      if (rd_en) rd_raw_q        <= mem[rd_idx];
    end
  end

  assign rd_word1 = rd_sel1_q ? g_bank[1].rd_raw_q : g_bank[0].rd_raw_q;

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data  = rd_v1_q ? rd_word1 : '0;
    assign rd_valid = rd_v1_q;
  end else begin : g_lat2
    logic [W-1:0] rd_data_q, rd_data_d;
    logic         rd_valid_q;
    always_comb rd_data_d = rd_v1_q ? rd_word1 : rd_data_q;
    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_v1_q;
      end
    end
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

  assign swap_done   = swap_done_q;
  assign front_sel   = front_sel_q;
  assign write_count = write_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pingpong_particle_buffer.sv
// Scoreboard bench: stimulus drives a frame-level reference model; a monitor checks read returns.
module tb_pingpong_particle_buffer;
  localparam int W   = 64;
  localparam int MAXP = 128;
  localparam int LAT = 2;
  localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_PEND = 3;

  logic          clk_in = 1'b0;
  logic          rst_in_n = 1'b0;
  logic [15:0]   particle_count = '0;
  logic          restart = 0, init_we = 0, init_done = 0, rd_en = 0, wr_en = 0, swap_req = 0;
  logic [15:0]   init_addr = '0, rd_addr = '0, wr_addr = '0;
  logic [W-1:0]  init_data = '0, wr_data = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid, swap_done, front_sel, busy, err;
  logic [15:0]   write_count;

  pingpong_particle_buffer dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .particle_count(particle_count),
    .restart(restart), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .init_done(init_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
    .write_count(write_count), .busy(busy), .err(err)
  );

  always #5 clk_in = ~clk_in;

  int edge_n = 0;
  always @(posedge clk_in) edge_n <= edge_n + 1;

  int nvec = 0;
  int nfail = 0;

  typedef struct { logic [W-1:0] data; int due; } rd_exp_t;
  rd_exp_t exp_q[$];

  logic [W-1:0] m_bank [2][MAXP];
  bit   m_seen [MAXP];
  int   m_count = 0, m_phase = P_IDLE;
  bit   m_front = 0, m_err = 0, m_sd = 0;

  function automatic int seen_count();
    int n = 0;
    foreach (m_seen[i]) if (m_seen[i]) n++;
    return n;
  endfunction

  function automatic bit frame_complete();
    for (int i = 0; i < m_count; i++) if (!m_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_seen[i]) m_seen[i] = 0;
    m_count = 0; m_phase = P_IDLE; m_front = 0; m_err = 0; m_sd = 0;
  endtask

  // Applies the current input vector to the reference model for one clock edge.
  task automatic model_step();
    int a;
    bit want;
    rd_exp_t e;
    if (rd_en) begin
      e.data = m_bank[m_front][rd_addr % MAXP];
      e.due  = edge_n + LAT;
      exp_q.push_back(e);
    end
    m_sd = 0;
    if (restart) begin
      foreach (m_seen[i]) m_seen[i] = 0;
      m_err = 0; m_count = particle_count; m_phase = P_INIT;
      return;
    end
    if (rd_en && rd_addr >= m_count) m_err = 1;
    if (m_phase == P_INIT) begin
      if (init_we) begin
        a = init_addr % MAXP;
        m_bank[0][a] = init_data;
        m_bank[1][a] = init_data;
        if (init_addr >= m_count) m_err = 1;
      end
      if (wr_en || swap_req) m_err = 1;
      if (init_done) m_phase = P_RUN;
    end else if (m_phase == P_IDLE) begin
      if (init_we || wr_en || swap_req) m_err = 1;
    end else begin
      want = swap_req || (m_phase == P_PEND);
      if (init_we) m_err = 1;
      if (wr_en) begin
        if (wr_addr < m_count) begin
          a = wr_addr % MAXP;
          m_bank[!m_front][a] = wr_data;
          if (m_seen[a]) m_err = 1;
          else m_seen[a] = 1;
        end else m_err = 1;
      end
      if (want && frame_complete()) begin
        m_front = !m_front;
        foreach (m_seen[i]) m_seen[i] = 0;
        m_count = particle_count;
        m_sd = 1;
        m_phase = P_RUN;
      end else if (swap_req) m_phase = P_PEND;
    end
  endtask

  task automatic check_status();
    chk("front_sel", front_sel, m_front);
    chk("write_count", write_count, seen_count());
    chk("err", err, m_err);
    chk("busy", busy, m_phase != P_RUN);
    chk("swap_done", swap_done, m_sd);
  endtask

  task automatic idle_inputs();
    restart = 0; init_we = 0; init_done = 0; rd_en = 0; wr_en = 0; swap_req = 0;
  endtask

  // Called at a negedge with inputs set: model the edge, cross it, check, clear pulses.
  task automatic commit();
    model_step();
    @(negedge clk_in);
    check_status();
    idle_inputs();
  endtask

  task automatic do_restart(int pc);
    particle_count = 16'(pc); restart = 1; commit();
  endtask

  task automatic init_word(int a, logic [W-1:0] d);
    init_we = 1; init_addr = 16'(a); init_data = d; commit();
  endtask

  task automatic op(bit we, int wa, logic [W-1:0] wd, bit re, int ra, bit sw);
    wr_en = we; wr_addr = 16'(wa); wr_data = wd;
    rd_en = re; rd_addr = 16'(ra); swap_req = sw;
    commit();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) commit();
  endtask

  task automatic async_reset();
    #2 rst_in_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_front_sel", front_sel, 0);
    chk("rst_write_count", write_count, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in_n = 1'b1;
  endtask

  initial begin : monitor
    rd_exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in_n) continue;
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL rd_unexpected at edge %0d: got rd_valid=1 data %h expected no read", edge_n, rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_latency", edge_n, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
        nvec++; nfail++;
        $display("FAIL rd_missing at edge %0d: got rd_valid=%b expected a read due at edge %0d", edge_n, rd_valid, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL timeout: got no finish expected completion within 400us");
    $fatal(1);
  end

  initial begin : stimulus
    int r;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_status();
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    rst_in_n = 1'b1;

    // Fill every entry so later reads never see uninitialised memory.
    do_restart(MAXP);
    for (int i = 0; i < MAXP; i++) init_word(i, {$urandom, $urandom});
    init_done = 1; commit();

    do_restart(4);
    for (int i = 0; i < 4; i++) init_word(i, W'(i));
    init_done = 1; commit();
    op(0, 0, 0, 1, 2, 0);
    idle(3);

    // Frame writes i so both banks hold i after the swap.
    for (int i = 0; i < 4; i++) op(1, i, W'(i), 0, 0, i == 3);
    op(0, 0, 0, 1, 2, 0);
    idle(3);

    // Reads one cycle before and on the swap edge must return the old front.
    for (int i = 0; i < 3; i++) op(1, i, W'(32'h100 + i), 0, 0, 0);
    op(0, 0, 0, 1, 0, 0);
    op(1, 3, W'(32'h103), 1, 0, 1);
    op(0, 0, 0, 1, 3, 0);
    idle(3);

    // Early swap request waits in the pending state.
    op(1, 0, W'(32'h200), 0, 0, 0);
    op(1, 1, W'(32'h201), 0, 0, 0);
    op(0, 0, 0, 0, 0, 1);
    idle(2);
    op(0, 0, 0, 0, 0, 1);
    op(1, 2, W'(32'h202), 0, 0, 0);
    op(1, 3, W'(32'h203), 1, 0, 0);
    op(0, 0, 0, 1, 3, 0);
    idle(3);

    // Duplicate and out-of-range writes.
    op(1, 1, W'(32'h301), 0, 0, 0);
    op(1, 1, W'(32'h311), 0, 0, 0);
    op(1, 5, W'(32'h305), 0, 0, 0);
    op(1, 0, W'(32'h300), 0, 0, 0);
    op(1, 2, W'(32'h302), 0, 0, 0);
    op(1, 3, W'(32'h303), 0, 0, 1);
    op(0, 0, 0, 1, 1, 0);
    op(0, 0, 0, 1, 5, 0);
    idle(3);

    // Reset while a swap is pending.
    do_restart(4);
    init_done = 1; commit();
    op(1, 0, W'(32'h400), 0, 0, 1);
    op(1, 1, W'(32'h401), 1, 1, 0);
    async_reset();
    idle(3);
    op(0, 0, 0, 0, 0, 1);
    idle(2);

    do_restart($urandom_range(1, 16));
    for (int c = 0; c < 900; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        particle_count = 16'($urandom_range(1, 16));
        restart = 1;
      end else if (m_phase == P_INIT) begin
        init_we   = $urandom_range(0, 1);
        init_addr = 16'($urandom_range(0, m_count - 1));
        init_data = {$urandom, $urandom};
        init_done = ($urandom_range(0, 3) == 0);
      end else begin
        wr_en    = ($urandom_range(0, 9) < 6);
        wr_addr  = 16'($urandom_range(0, m_count));
        wr_data  = {$urandom, $urandom};
        swap_req = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) particle_count = 16'($urandom_range(1, 16));
      end
      rd_en   = $urandom_range(0, 1);
      rd_addr = 16'(($urandom_range(0, 9) == 0) ? $urandom_range(0, MAXP - 1)
                                                : $urandom_range(0, (m_count > 0) ? m_count - 1 : 0));
      commit();
    end

    idle(4);
    chk("rd_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
